// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the bus_A arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_MAX_BURST = 16;

   // Index width that stays at least one bit wide for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               pick_vld
);

   // Scan requesters starting at ptr; the first hit wins and later hits are ignored.
   always_comb begin
      int j;
      logic [IDX_W-1:0] jj;
      j        = 0;
      jj       = '0;
      pick     = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         jj = IDX_W'(j);
         if (!pick_vld && req[jj]) begin
            pick_vld = 1'b1;
            pick[jj] = 1'b1;
            pick_idx = jj;
         end
      end
   end

endmodule

// File: rtl/bus_a_arbiter.sv
// Round-robin arbiter granting shared bus_A to one requester per burst, with forced release after MAX_BURST beats.
// Latency: grant registered one cycle after a request seen in IDLE; one IDLE bubble between grants.
// Backpressure: bus_ready passes straight through to the granted requester's req_ready; beats stall in place.
module bus_a_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         bus_A,
   output logic                      bus_valid,
   output logic                      bus_last,
   input  logic                      bus_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      burst_abort
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = idx_width(MAX_BURST) + 1;

   localparam logic [0:0]       S_IDLE   = IDLE;
   localparam logic [0:0]       S_BUSY   = BUSY;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST - 1);

   logic [0:0]         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               burst_abort_q, burst_abort_d;

   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;

   logic [DATA_W-1:0]  sel_data;
   logic               sel_vld;
   logic               sel_last;
   logic               at_max;
   logic               accept;
   logic [IDX_W-1:0]   next_ptr;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .req      (req),
      .ptr      (rr_ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   // Steer the granted requester onto the bus; grant_q is zero in IDLE so everything reads zero there.
   always_comb begin
      sel_data = '0;
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            sel_vld  = sel_vld  | req[i];
            sel_last = sel_last | req_last[i];
         end
      end
   end

   assign busy        = (state_q == S_BUSY);
   assign at_max      = (beat_cnt_q == CNT_MAX);
   assign bus_A       = sel_data;
   assign bus_valid   = sel_vld;
   assign bus_last    = busy & (sel_last | at_max);
   assign req_ready   = grant_q & {NUM_REQ{bus_ready}};
   assign grant       = grant_q;
   assign burst_abort = burst_abort_q;
   assign accept      = busy & sel_vld & bus_ready;
   assign next_ptr    = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

   // FSM: latch a round-robin pick in IDLE, count beats in BUSY, release on last beat or burst limit.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      gidx_d        = gidx_q;
      rr_ptr_d      = rr_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      burst_abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d    = S_BUSY;
               grant_d    = pick;
               gidx_d     = pick_idx;
               beat_cnt_d = '0;
            end
         end
         S_BUSY: begin
            if (accept) begin
               if (sel_last || at_max) begin
                  // A limit hit without the requester's own last beat is a forced release.
                  state_d       = S_IDLE;
                  grant_d       = '0;
                  beat_cnt_d    = '0;
                  rr_ptr_d      = next_ptr;
                  burst_abort_d = at_max & ~sel_last;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
         end
      endcase
   end

   // State registers; reset drops the grant at once so nothing can be accepted while it is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         gidx_q        <= '0;
         rr_ptr_q      <= '0;
         beat_cnt_q    <= '0;
         burst_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         gidx_q        <= gidx_d;
         rr_ptr_q      <= rr_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         burst_abort_q <= burst_abort_d;
      end
   end

endmodule

// File: tb/tb_bus_a_arbiter.sv
// Directed bench for bus_a_arbiter: single grant, fairness, backpressure, forced release, reset mid-burst.
// Latency: inputs driven 2 ns after the rising edge, outputs checked 1 ns later.
// Backpressure: bus_ready toggled by the stimulus.
module tb_bus_a_arbiter;

   logic         clk;
   logic         reset;
   logic [3:0]   req;
   logic [127:0] req_data;
   logic [3:0]   req_last;
   logic [3:0]   req_ready;
   logic [31:0]  bus_A;
   logic         bus_valid;
   logic         bus_last;
   logic         bus_ready;
   logic [3:0]   grant;
   logic         busy;
   logic         burst_abort;

   int checks;
   int failures;
   int acc_cnt;
   int acc_snap;

   bus_a_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .bus_A       (bus_A),
      .bus_valid   (bus_valid),
      .bus_last    (bus_last),
      .bus_ready   (bus_ready),
      .grant       (grant),
      .busy        (busy),
      .burst_abort (burst_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count accepted beats as seen just before the rising edge that takes them.
   always @(negedge clk) begin
      if (bus_valid && bus_ready) acc_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      checks    = 0;
      failures  = 0;
      acc_cnt   = 0;
      reset     = 1'b1;
      req       = '0;
      req_data  = '0;
      req_last  = '0;
      bus_ready = 1'b0;
      #2;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(bus_valid), 0);
      chk("rst_abort", 32'(burst_abort), 0);
      chk("rst_bus_A", bus_A, 0);
      // Requests offered while reset is high must not be granted.
      req = 4'b0001; req_last = 4'b0001; bus_ready = 1'b1;
      cyc();
      settle();
      chk("rst_hold_ready", 32'(req_ready), 0);
      chk("rst_hold_grant", 32'(grant), 0);

      // Single request from requester 0.
      req = 4'b0000;
      cyc();
      reset = 1'b0;
      req = 4'b0001; req_data[31:0] = 32'd1563167184; req_last = 4'b0001; bus_ready = 1'b1;
      settle();
      chk("single_idle_busy", 32'(busy), 0);
      chk("single_idle_valid", 32'(bus_valid), 0);
      cyc();
      settle();
      chk("single_grant", 32'(grant), 32'b0001);
      chk("single_valid", 32'(bus_valid), 1);
      chk("single_bus_A", bus_A, 32'd1563167184);
      chk("single_last", 32'(bus_last), 1);
      chk("single_ready", 32'(req_ready), 32'b0001);
      cyc();
      req = 4'b0000;
      settle();
      chk("single_release_busy", 32'(busy), 0);
      chk("single_release_grant", 32'(grant), 0);
      chk("single_no_abort", 32'(burst_abort), 0);

      // Pointer now 1: with requesters 0 and 3 pending, 3 wins.
      req = 4'b1001; req_last = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 + 32'(i);
      cyc();
      settle();
      chk("ptr1_grant", 32'(grant), 32'b1000);
      chk("ptr1_bus_A", bus_A, 32'h103);

      // Fairness: all four requesting 1-beat bursts.
      req = 4'b1111;
      cyc();
      settle();
      chk("fair_bubble0", 32'(busy), 0);
      for (int n = 0; n < 5; n++) begin
         cyc();
         settle();
         chk("fair_grant", 32'(grant), 32'(1) << order[n]);
         chk("fair_bus_A", bus_A, 32'h100 + 32'(order[n]));
         cyc();
         if (n == 4) req = 4'b0000;
         settle();
         chk("fair_bubble", 32'(busy), 0);
         chk("fair_bubble_grant", 32'(grant), 0);
      end

      // Backpressure: requester 2, three beats, bus_ready low every other cycle. Pointer is 1.
      acc_snap = acc_cnt;
      req = 4'b0100; req_last = 4'b0000; req_data[64 +: 32] = 32'd36339; bus_ready = 1'b0;
      cyc();
      settle();
      chk("bp_grant_b0", 32'(grant), 32'b0100);
      chk("bp_data_b0_stall", bus_A, 32'd36339);
      chk("bp_ready_b0_stall", 32'(req_ready), 0);
      chk("bp_last_b0", 32'(bus_last), 0);
      cyc();
      bus_ready = 1'b1;
      settle();
      chk("bp_data_b0", bus_A, 32'd36339);
      chk("bp_ready_b0", 32'(req_ready), 32'b0100);
      cyc();
      req_data[64 +: 32] = 32'd48; bus_ready = 1'b0;
      settle();
      chk("bp_grant_b1", 32'(grant), 32'b0100);
      chk("bp_data_b1_stall", bus_A, 32'd48);
      cyc();
      bus_ready = 1'b1;
      settle();
      chk("bp_data_b1", bus_A, 32'd48);
      cyc();
      req_data[64 +: 32] = 32'd12; req_last = 4'b0100; bus_ready = 1'b0;
      settle();
      chk("bp_grant_b2", 32'(grant), 32'b0100);
      chk("bp_data_b2_stall", bus_A, 32'd12);
      chk("bp_last_b2", 32'(bus_last), 1);
      cyc();
      bus_ready = 1'b1;
      settle();
      chk("bp_data_b2", bus_A, 32'd12);
      cyc();
      req = 4'b0000;
      settle();
      chk("bp_release", 32'(busy), 0);
      chk("bp_accept_count", 32'(acc_cnt - acc_snap), 3);

      // Forced release: requester 1 never raises last; requester 2 also waiting. Pointer is 3.
      req = 4'b0110; req_last = 4'b0000; bus_ready = 1'b1; req_data[64 +: 32] = 32'h2222;
      cyc();
      for (int b = 0; b < 16; b++) begin
         req_data[32 +: 32] = 32'd1000 + 32'(b);
         settle();
         chk("abort_grant", 32'(grant), 32'b0010);
         chk("abort_bus_A", bus_A, 32'd1000 + 32'(b));
         chk("abort_bus_last", 32'(bus_last), (b == 15) ? 32'd1 : 32'd0);
         chk("abort_pulse_low", 32'(burst_abort), 0);
         cyc();
      end
      settle();
      chk("abort_release_busy", 32'(busy), 0);
      chk("abort_pulse", 32'(burst_abort), 1);
      chk("abort_release_grant", 32'(grant), 0);
      cyc();
      settle();
      chk("abort_next_grant", 32'(grant), 32'b0100);
      chk("abort_pulse_cleared", 32'(burst_abort), 0);
      chk("abort_next_bus_A", bus_A, 32'h2222);
      req = 4'b0100; req_last = 4'b0100;
      cyc();
      req = 4'b0000;
      settle();
      chk("abort_r2_done", 32'(busy), 0);

      // Reset mid-burst: requester 2 burst, reset during its second beat. Pointer is 3.
      req = 4'b0100; req_last = 4'b0000; bus_ready = 1'b1;
      cyc();
      settle();
      chk("rmid_grant", 32'(grant), 32'b0100);
      cyc();
      settle();
      chk("rmid_beat2_valid", 32'(bus_valid), 1);
      reset = 1'b1;
      settle();
      chk("rmid_grant_dropped", 32'(grant), 0);
      chk("rmid_valid_dropped", 32'(bus_valid), 0);
      chk("rmid_ready_dropped", 32'(req_ready), 0);
      acc_snap = acc_cnt;
      cyc();
      settle();
      chk("rmid_no_accept", 32'(acc_cnt - acc_snap), 0);
      reset = 1'b0;
      req = 4'b1111; req_last = 4'b1111;
      cyc();
      settle();
      chk("rmid_restart_grant", 32'(grant), 32'b0001);
      cyc();
      req = 4'b0000;
      settle();
      chk("rmid_restart_release", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_a_arbiter.md
BUS_A_ARBITER -- requirements
Module: bus_a_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing bus_A.
REQ-002 SHALL have parameter DATA_W, default 32, width of bus_A and each requester's data.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant before forced release.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester valid (beat offered).
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_W, flattened data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_last, input, NUM_REQ, final beat of the requester's burst.
REQ-009 SHALL have port req_ready, output, NUM_REQ, beat accepted from requester i when req[i] and req_ready[i] are both high.
REQ-010 SHALL have port bus_A, output, DATA_W, shared datapath bus.
REQ-011 SHALL have port bus_valid, output, 1, bus_A carries a valid beat.
REQ-012 SHALL have port bus_last, output, 1, current beat is the final beat of the burst.
REQ-013 SHALL have port bus_ready, input, 1, sink accepts the beat.
REQ-014 SHALL have port grant, output, NUM_REQ, one-hot registered grant vector.
REQ-015 SHALL have port busy, output, 1, high while in BUSY state.
REQ-016 SHALL have port burst_abort, output, 1, one-cycle pulse on forced release.

Function
REQ-017 SHALL implement two states: IDLE and BUSY.
REQ-018 In IDLE with any req bit set, SHALL pick the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), register grant one-hot, and enter BUSY next cycle.
REQ-019 In IDLE, SHALL drive grant=0, bus_valid=0, req_ready=0, bus_A=0.
REQ-020 In BUSY with granted index g, SHALL drive bus_A=req_data[g], bus_valid=req[g], bus_last=req_last[g] or (beat_cnt==MAX_BURST-1), req_ready[g]=bus_ready, and all other req_ready bits 0.
REQ-021 A beat SHALL be accepted when bus_valid and bus_ready are both high; beat_cnt SHALL increment on each accepted beat.
REQ-022 The grant SHALL be held while req[g] drops mid-burst; bus_valid follows req[g] with no release.
REQ-023 On an accepted beat with req_last[g]=1, SHALL return to IDLE, clear beat_cnt, and set rr_ptr=(g+1) mod NUM_REQ.
REQ-024 On an accepted beat with beat_cnt==MAX_BURST-1 and req_last[g]=0, SHALL return to IDLE, pulse burst_abort for one cycle, clear beat_cnt, and advance rr_ptr as in REQ-023.
REQ-025 Latency SHALL be one cycle from req high in IDLE to bus_valid high, with one IDLE bubble cycle between consecutive grants.
REQ-026 Requests arriving during BUSY SHALL wait; they SHALL not preempt the grant.
REQ-027 A one-beat burst, where req_last is high on the first beat, SHALL be legal and release after that beat.

Reset
REQ-028 Reset SHALL force state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, burst_abort=0, and therefore bus_valid=0, req_ready=0, bus_A=0.
REQ-029 Reset asserted mid-burst SHALL drop the grant immediately; no beat SHALL be accepted while reset is high.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the default constants for NUM_REQ, DATA_W and MAX_BURST.
REQ-031 Round-robin selection SHALL live in one sub-module, rr_picker, taking the request vector and rr_ptr and returning a one-hot pick and a valid flag.

Verification
REQ-032 Single request: req=4'b0001, req_data[0]=32'd1563167184, req_last=1, bus_ready=1 -> bus_A=1563167184 with bus_valid one cycle after req; IDLE then; rr_ptr=1.
REQ-033 Fairness: req=4'b1111 held, each requester sends 1-beat bursts -> grant order 0,1,2,3,0 with one bubble cycle between grants.
REQ-034 Backpressure: requester 2 sends a 3-beat burst of 36339, 48, 12 with bus_ready low every other cycle -> all three beats appear in order, each accepted exactly once; grant held throughout.
REQ-035 Abort: requester 1 sends 20 beats with req_last=0 -> release after beat 16, bus_last high on beat 16, one-cycle burst_abort pulse, next grant to requester 2 if it is requesting.
REQ-036 Reset mid-burst: assert reset during beat 2 of a burst -> grant=0, bus_valid=0 immediately; after release, arbitration restarts from requester 0.
